// File: rtl/mul_arb_2port.sv
// Round-robin arbiter sharing one external 32x32 multiplier between two val/rdy requesters.
// Optional performance counters are enabled with `define MUL_ARB_PERF_EN.
module mul_arb_2port #(
  parameter int unsigned MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_val,
  output logic [1:0]  req_rdy,
  input  logic [31:0] req_in0_0,
  input  logic [31:0] req_in1_0,
  input  logic [31:0] req_in0_1,
  input  logic [31:0] req_in1_1,
  output logic [1:0]  resp_val,
  input  logic [1:0]  resp_rdy,
  output logic [31:0] resp_prod,
  output logic [31:0] mul_in0,
  output logic [31:0] mul_in1,
  input  logic [31:0] mul_prod
`ifdef MUL_ARB_PERF_EN
  ,
  output logic [31:0] perf_cnt0,
  output logic [31:0] perf_cnt1,
  output logic [31:0] perf_stall
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DW    = 32;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;

  state_e           state_q;
  logic             prio_q;
  logic             owner_q;
  logic [DW-1:0]    op0_q;
  logic [DW-1:0]    op1_q;
  logic [DW-1:0]    res_q;
  logic [CNT_W-1:0] cnt_q;

  logic          gnt;
  logic          fire;
  logic          resp_done;
  logic [DW-1:0] gnt_in0;
  logic [DW-1:0] gnt_in1;

  // Grant: lone requester wins, otherwise the prio holder wins
  always_comb begin
    gnt     = (req_val == 2'b11) ? prio_q : req_val[1];
    req_rdy = 2'b00;
    if (reset && (state_q == IDLE) && (|req_val)) begin
      req_rdy = gnt ? 2'b10 : 2'b01;
    end
    fire      = |(req_val & req_rdy);
    gnt_in0   = gnt ? req_in0_1 : req_in0_0;
    gnt_in1   = gnt ? req_in1_1 : req_in1_0;
    resp_val  = 2'b00;
    if (state_q == RESP) begin
      resp_val = owner_q ? 2'b10 : 2'b01;
    end
    resp_done = (state_q == RESP) && resp_rdy[owner_q];
  end

  assign mul_in0   = op0_q;
  assign mul_in1   = op1_q;
  assign resp_prod = res_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      op0_q   <= '0;
      op1_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fire) begin
            op0_q   <= gnt_in0;
            op1_q   <= gnt_in1;
            owner_q <= gnt;
            cnt_q   <= CNT_W'(MUL_LAT - 1);
            state_q <= CALC;
          end
        end
        CALC: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            res_q   <= mul_prod;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (resp_done) begin
            prio_q  <= ~owner_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MUL_ARB_PERF_EN
  logic [DW-1:0] perf_cnt0_q;
  logic [DW-1:0] perf_cnt1_q;
  logic [DW-1:0] perf_stall_q;

  // Completed handshakes per port and backpressured RESP cycles; all wrap
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_cnt0_q  <= '0;
      perf_cnt1_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (resp_done && !owner_q) perf_cnt0_q <= perf_cnt0_q + DW'(1);
      if (resp_done && owner_q)  perf_cnt1_q <= perf_cnt1_q + DW'(1);
      if ((state_q == RESP) && !resp_done) perf_stall_q <= perf_stall_q + DW'(1);
    end
  end

  assign perf_cnt0  = perf_cnt0_q;
  assign perf_cnt1  = perf_cnt1_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_mul_arb_2port.sv
// Directed self-checking bench for mul_arb_2port; one instance at MUL_LAT=1, one at MUL_LAT=3.
// Perf counter checks are compiled in when MUL_ARB_PERF_EN is defined.
module tb_mul_arb_2port;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in00, in10, in01, in11;

  logic [1:0]  req_val, req_rdy, resp_val, resp_rdy;
  logic [31:0] resp_prod, m0, m1, mp;
  logic [1:0]  req_val3, req_rdy3, resp_val3, resp_rdy3;
  logic [31:0] resp_prod3, m0_3, m1_3, mp3;
`ifdef MUL_ARB_PERF_EN
  logic [31:0] pc0, pc1, pst, pc0_3, pc1_3, pst_3;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // External multiplier models: low 32 bits of the product
  assign mp  = m0 * m1;
  assign mp3 = m0_3 * m1_3;

  mul_arb_2port #(.MUL_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(req_rdy),
    .req_in0_0(in00), .req_in1_0(in10), .req_in0_1(in01), .req_in1_1(in11),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_prod(resp_prod),
    .mul_in0(m0), .mul_in1(m1), .mul_prod(mp)
`ifdef MUL_ARB_PERF_EN
    , .perf_cnt0(pc0), .perf_cnt1(pc1), .perf_stall(pst)
`endif
  );

  mul_arb_2port #(.MUL_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .req_val(req_val3), .req_rdy(req_rdy3),
    .req_in0_0(in00), .req_in1_0(in10), .req_in0_1(in01), .req_in1_1(in11),
    .resp_val(resp_val3), .resp_rdy(resp_rdy3), .resp_prod(resp_prod3),
    .mul_in0(m0_3), .mul_in1(m1_3), .mul_prod(mp3)
`ifdef MUL_ARB_PERF_EN
    , .perf_cnt0(pc0_3), .perf_cnt1(pc1_3), .perf_stall(pst_3)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_val = 2'b11; req_val3 = 2'b00;
    resp_rdy = 2'b00; resp_rdy3 = 2'b00;
    in00 = '0; in10 = '0; in01 = '0; in11 = '0;
    step(); step(); settle();
    checks++; if (req_rdy !== 2'b00) begin errors++; $display("FAIL reset_req_rdy got=%b exp=00", req_rdy); end
    checks++; if (resp_val !== 2'b00) begin errors++; $display("FAIL reset_resp_val got=%b exp=00", resp_val); end
    checks++; if (resp_prod !== 32'h0) begin errors++; $display("FAIL reset_resp_prod got=%h exp=0", resp_prod); end
    checks++; if (m0 !== 32'h0 || m1 !== 32'h0) begin errors++; $display("FAIL reset_mul_in got=%h/%h exp=0/0", m0, m1); end
    reset = 1'b1; settle();
    checks++; if (req_rdy !== 2'b01) begin errors++; $display("FAIL release_req_rdy got=%b exp=01", req_rdy); end
    req_val = 2'b00;
    step();
  endtask

  task automatic test_single();
    req_val = 2'b01; in00 = 32'd50000; in10 = 32'd60000; resp_rdy = 2'b11; settle();
    checks++; if (req_rdy !== 2'b01) begin errors++; $display("FAIL single_grant got=%b exp=01", req_rdy); end
    step();
    checks++; if (req_rdy !== 2'b00) begin errors++; $display("FAIL single_calc_rdy got=%b exp=00", req_rdy); end
    checks++; if (resp_val !== 2'b00) begin errors++; $display("FAIL single_calc_val got=%b exp=00", resp_val); end
    checks++; if (m0 !== 32'd50000 || m1 !== 32'd60000) begin errors++; $display("FAIL single_mul_in got=%h/%h exp=0000c350/0000ea60", m0, m1); end
    req_val = 2'b00;
    step();
    checks++; if (resp_val !== 2'b01) begin errors++; $display("FAIL single_resp_val got=%b exp=01", resp_val); end
    checks++; if (resp_prod !== 32'hB2D05E00) begin errors++; $display("FAIL single_prod got=%h exp=b2d05e00", resp_prod); end
    req_val = 2'b01; settle();
    checks++; if (req_rdy !== 2'b00) begin errors++; $display("FAIL single_resp_rdy got=%b exp=00", req_rdy); end
    req_val = 2'b00;
    step();
    checks++; if (resp_val !== 2'b00) begin errors++; $display("FAIL single_done_val got=%b exp=00", resp_val); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_g;
    logic [31:0] exp_p;
    reset = 1'b0; step(); reset = 1'b1;
    in00 = 32'hFFFFFFFF; in10 = 32'hFFFFFFFF; in01 = 32'hFFFFFFFE; in11 = 32'h00000002;
    req_val = 2'b11; resp_rdy = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_p = (k % 2 == 0) ? 32'h00000001 : 32'hFFFFFFFC;
      settle();
      checks++; if (req_rdy !== exp_g) begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", k, req_rdy, exp_g); end
      step(); step();
      checks++; if (resp_val !== exp_g) begin errors++; $display("FAIL rr_resp_val%0d got=%b exp=%b", k, resp_val, exp_g); end
      checks++; if (resp_prod !== exp_p) begin errors++; $display("FAIL rr_prod%0d got=%h exp=%h", k, resp_prod, exp_p); end
      step();
    end
    req_val = 2'b00;
  endtask

  task automatic test_backpressure();
    in01 = 32'h0000FFFF; in11 = 32'h0000FFFF; in00 = 32'd3; in10 = 32'd7;
    req_val = 2'b10; resp_rdy = 2'b01; settle();
    checks++; if (req_rdy !== 2'b10) begin errors++; $display("FAIL bp_grant got=%b exp=10", req_rdy); end
    step(); req_val = 2'b00; step();
    req_val = 2'b11;
    for (int k = 0; k < 5; k++) begin
      settle();
      checks++; if (resp_val !== 2'b10) begin errors++; $display("FAIL bp_val%0d got=%b exp=10", k, resp_val); end
      checks++; if (resp_prod !== 32'hFFFE0001) begin errors++; $display("FAIL bp_prod%0d got=%h exp=fffe0001", k, resp_prod); end
      checks++; if (req_rdy !== 2'b00) begin errors++; $display("FAIL bp_rdy%0d got=%b exp=00", k, req_rdy); end
      step();
    end
    resp_rdy = 2'b10; step(); settle();
    checks++; if (req_rdy !== 2'b01) begin errors++; $display("FAIL bp_next_grant got=%b exp=01", req_rdy); end
    req_val = 2'b01; step(); req_val = 2'b00; step();
    checks++; if (resp_val !== 2'b01 || resp_prod !== 32'd21) begin errors++; $display("FAIL bp_port0 got=%b/%h exp=01/00000015", resp_val, resp_prod); end
    resp_rdy = 2'b11; step();
  endtask

  task automatic test_lat3();
    in00 = 32'd100000; in10 = 32'd100000; resp_rdy3 = 2'b11; req_val3 = 2'b01; settle();
    checks++; if (req_rdy3 !== 2'b01) begin errors++; $display("FAIL lat3_grant got=%b exp=01", req_rdy3); end
    step(); req_val3 = 2'b00;
    for (int k = 0; k < 3; k++) begin
      settle();
      checks++; if (m0_3 !== 32'h000186A0 || m1_3 !== 32'h000186A0) begin errors++; $display("FAIL lat3_mul_in%0d got=%h/%h exp=000186a0", k, m0_3, m1_3); end
      checks++; if (resp_val3 !== 2'b00) begin errors++; $display("FAIL lat3_calc_val%0d got=%b exp=00", k, resp_val3); end
      step();
    end
    checks++; if (resp_val3 !== 2'b01) begin errors++; $display("FAIL lat3_resp_val got=%b exp=01", resp_val3); end
    checks++; if (resp_prod3 !== 32'h540BE400) begin errors++; $display("FAIL lat3_prod got=%h exp=540be400", resp_prod3); end
    step();
    checks++; if (resp_val3 !== 2'b00) begin errors++; $display("FAIL lat3_done got=%b exp=00", resp_val3); end
  endtask

  task automatic test_reset_mid_and_perf();
    int seen;
    in01 = 32'd5; in11 = 32'd9; req_val3 = 2'b10; resp_rdy3 = 2'b11;
    step(); req_val3 = 2'b00; step();
    reset = 1'b0; step(); reset = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      settle();
      if (resp_val3 !== 2'b00) seen++;
      step();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_reset_resp cycles_valid=%0d exp=0", seen); end
    checks++; if (resp_prod3 !== 32'h0) begin errors++; $display("FAIL mid_reset_prod got=%h exp=0", resp_prod3); end
    for (int k = 0; k < 3; k++) begin
      req_val = 2'b10; resp_rdy = (k == 0) ? 2'b00 : 2'b10;
      step(); req_val = 2'b00; step();
      if (k == 0) begin step(); step(); resp_rdy = 2'b10; end
      step();
    end
    settle();
    checks++; if (resp_val !== 2'b00) begin errors++; $display("FAIL perf_idle got=%b exp=00", resp_val); end
`ifdef MUL_ARB_PERF_EN
    checks++; if (pc1 !== 32'd3) begin errors++; $display("FAIL perf_cnt1 got=%0d exp=3", pc1); end
    checks++; if (pc0 !== 32'd0) begin errors++; $display("FAIL perf_cnt0 got=%0d exp=0", pc0); end
    checks++; if (pst !== 32'd2) begin errors++; $display("FAIL perf_stall got=%0d exp=2", pst); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_lat3();
    test_reset_mid_and_perf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_arb_2port.md
Name: mul_arb_2port

Overview:
- Shares one combinational 32x32b multiplier (low 32 bits of product) between two requesters, e.g. an execute-stage MUL and an address-generation unit.
- Each requester uses a val/rdy request interface and a val/rdy response interface.
- Arbitration is round-robin. Operands are registered into the shared multiplier, and the result is buffered until the owning requester accepts it.
- Sits between the requesters and the Multiplier_32x32b_RTL instance.

Parameters:
- MUL_LAT, 1: cycles operands are held on mul_in* before mul_prod is sampled. Legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low; reset==0 at a rising edge resets the block.
- req_val  input  2  request valid, bit i = requester i.
- req_rdy  output  2  request ready, bit i = requester i.
- req_in0_0, req_in1_0  input  32 each  operands, requester 0.
- req_in0_1, req_in1_1  input  32 each  operands, requester 1.
- resp_val  output  2  response valid per requester.
- resp_rdy  input  2  response ready per requester.
- resp_prod  output  32  product; shared bus, qualified by resp_val.
- mul_in0, mul_in1  output  32 each  operands to the shared multiplier.
- mul_prod  input  32  product from the shared multiplier.

Behaviour:
- Registered state: FSM state, prio (1b), owner (1b), op0/op1 (32b each), res (32b), cnt (4b).

Reset (reset==0 at a clock edge):
- state=IDLE, prio=0, owner=0, op0=op1=res=0, cnt=0.
- Outputs: resp_val=2'b00, req_rdy=2'b00, resp_prod=0, mul_in0=mul_in1=0.
- Reset mid-operation (CALC or RESP) abandons the operation. No response is ever issued for it.

IDLE:
- Grant, combinational:
  - Only one req_val bit set: that requester is granted.
  - Both set: requester prio is granted.
- req_rdy: the granted bit only. req_rdy=0 in all other states and when nothing is valid.
- On fire (req_val[g] & req_rdy[g]):
  - op0/op1 <= granted operands, owner <= g, cnt <= MUL_LAT-1.
  - -> CALC.

CALC:
- mul_in0=op0, mul_in1=op1. These equal op registers in every state; they are 0 only after reset.
- cnt!=0: cnt <= cnt-1, stay in CALC.
- cnt==0: res <= mul_prod, -> RESP.
- Occupancy is exactly MUL_LAT cycles.

RESP:
- resp_val[owner]=1, other bit 0. resp_prod=res in every state.
- On resp_rdy[owner]: -> IDLE, prio <= ~owner.
- resp_rdy of the non-owner is ignored.
- Holds indefinitely under backpressure. res and resp_val remain stable while waiting.

Timing and ordering rules:
- Minimum request-fire to response-valid latency: MUL_LAT+1 cycles.
- Maximum throughput: one operation per MUL_LAT+2 cycles. No new request is accepted until the response handshake completes, so there is no overlap.
- Fairness: after a grant to port i, port ~i wins the next simultaneous contention. A lone requester is never blocked by prio.
- Requester operands need only be stable in the fire cycle.
- Dropping req_val before fire is allowed; no state changes.
- The product is the low 32 bits of in0*in1, identical for signed and unsigned operands. No overflow flag.

Optional Feature:
- Macro: MUL_ARB_PERF_EN.
- Defined:
  - Adds output ports perf_cnt0 and perf_cnt1, each 32 bits.
  - perf_cnti increments on each completed response handshake of port i (resp_val[i] & resp_rdy[i]).
  - Wraps 32'hFFFFFFFF -> 0.
  - Cleared to 0 on reset.
  - Adds output perf_stall (32b): counts cycles in RESP with resp_rdy[owner]==0. Same wrap and reset rules.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
1. Reset then idle: hold reset=0 for 2 cycles with req_val=2'b11 -> req_rdy=00, resp_val=00, resp_prod=0. Release reset -> req_rdy=2'b01 in the next IDLE cycle (prio=0).
2. Single request, MUL_LAT=1:
   - Port 0 sends 32'd50000 * 32'd60000, resp_rdy=2'b11.
   - resp_val=2'b01 two cycles after fire, resp_prod=32'hB2D05E00.
   - req_rdy=0 during CALC and RESP.
3. Round-robin contention, both ports valid continuously:
   - Port 0 sends FFFFFFFF*FFFFFFFF; port 1 sends FFFFFFFE*00000002.
   - Grant order 0,1,0,1.
   - Responses alternate: 32'h00000001 on port 0, 32'hFFFFFFFC on port 1.
4. Backpressure:
   - Port 1 sends 0000FFFF*0000FFFF, resp_rdy[1]=0 for 5 cycles.
   - resp_val=2'b10, resp_prod=32'hFFFE0001 stable all 5 cycles.
   - A port 0 request stays unaccepted until resp_rdy[1]=1; it is granted next.
5. MUL_LAT=3:
   - Port 0 sends 32'd100000*32'd100000.
   - mul_in0/mul_in1=000186A0 for exactly 3 CALC cycles.
   - resp_val rises 4 cycles after fire, resp_prod=32'h540BE400.
6. Reset mid-CALC and PERF:
   - Assert reset=0 during CALC -> no resp_val ever rises for that request.
   - With MUL_ARB_PERF_EN, 3 completed port-1 responses after reset -> perf_cnt1=3, perf_cnt0=0.
